// File: rtl/adc_sched_pkg.sv
// ============================================================================
// Module      : adc_sched_pkg
// Description : Shared types and constants for the ADC sample scheduler:
//               FSM state encoding, requester count, sample width, defaults
//               and small helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_sched_pkg;

  // Number of requesters sharing the ADC
  localparam int NUM_REQ = 2;

  // Width of one ADC sample
  localparam int ADC_W = 10;

  // Default conversion watchdog and inter-conversion spacing (sysclk cycles)
  localparam int DEF_TIMEOUT_CYCLES = 2048;
  localparam int DEF_GAP_CYCLES     = 50;

  // Scheduler FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  // Larger of two integers, used to size the shared WAIT/GAP counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One-hot completion vector for a granted requester index
  function automatic logic [NUM_REQ-1:0] grant_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Combinational two-way round-robin arbiter. A lone request
//               wins outright; on a tie the requester that was not served
//               last wins. The last-served pointer is held by the caller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
  import adc_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               last_i,
  output logic               gnt_valid_o,
  output logic               gnt_idx_o
);

  // Pick the winner from the request pattern and the last-served pointer
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_idx_o   = 1'b0;
    case (req_i)
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_i;
      default: gnt_idx_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/adc_sample_scheduler.sv
// ============================================================================
// Module      : adc_sample_scheduler
// Description : Shares one spi2adc converter between two requesters. Grants
//               round-robin, pulses adc_start, waits for a rising edge of
//               adc_valid (or a watchdog timeout), returns the sample to the
//               granted requester and then enforces a minimum idle gap before
//               the next conversion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic               adc_start,
  input  logic [ADC_W-1:0]   adc_data,
  input  logic               adc_valid,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [ADC_W-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  // One counter serves both the WAIT watchdog and the GAP spacing
  localparam int CNT_W = $clog2(max_int(TIMEOUT_CYCLES, GAP_CYCLES) + 1);

  // Terminal counts; a zero gap still spends one cycle in GAP
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = (GAP_CYCLES == 0) ? '0
                                              : CNT_W'(GAP_CYCLES - 1);

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               grant_q;
  logic               last_q;
  logic               valid_q;
  logic               adc_start_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [ADC_W-1:0]   rsp_data_q;
  logic               rsp_err_q;
  logic               busy_q;

  logic               arb_valid;
  logic               arb_idx;
  logic               completion;

  rr_arbiter2 u_arb (
    .req_i       (req),
    .last_i      (last_q),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (arb_idx)
  );

  // A conversion finishes on a rising edge of the converter's valid strobe
  assign completion = adc_valid & ~valid_q;

  // Track adc_valid every cycle; reset high so a level held across reset
  // release is not mistaken for an edge
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b1;
    end else begin
      valid_q <= adc_valid;
    end
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      grant_q     <= 1'b0;
      last_q      <= 1'b1;
      adc_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to zero unless re-asserted below
      adc_start_q <= 1'b0;
      rsp_valid_q <= '0;

      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            grant_q     <= arb_idx;
            adc_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_START;
          end
        end

        ST_START: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          // Completion takes priority over a simultaneous timeout
          if (completion) begin
            rsp_data_q  <= adc_data;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= grant_onehot(grant_q);
            state_q     <= ST_DONE;
          end else if (cnt_q == TIMEOUT_LAST) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= grant_onehot(grant_q);
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
          last_q  <= grant_q;
          cnt_q   <= '0;
          state_q <= ST_GAP;
        end

        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign adc_start = adc_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
